// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial sequence detector.
// Imported by the detector top and its prefix-search sub-module.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W = 8;

    localparam logic [7:0] DEF_RST_PATTERN = 8'b0010_1011;
    localparam int DEF_RST_LEN = 6;
    localparam bit DEF_RST_OVERLAP = 1'b1;

    typedef enum logic {
        OVL_RESTART = 1'b0,
        OVL_KEEP    = 1'b1
    } ovl_mode_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Longest pattern prefix that ends the current history.
// Purely combinational; larger k overrides smaller k.
module seq_prefix_match
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W = len_w(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] hist,
    input  logic [LEN_W-1:0]   fill,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic [LEN_W-1:0]   prefix
);

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] shp;

    // Priority search over k = 1 .. MAX_LEN-1; the last hit is the longest.
    always_comb begin
        prefix = '0;
        mask = '0;
        shp = '0;
        for (int k = 1; k < MAX_LEN; k++) begin
            mask = MAX_LEN'((64'd1 << k) - 64'd1);
            shp = pattern >> (len - LEN_W'(k));
            if (LEN_W'(k) < len && fill >= LEN_W'(k) &&
                ((hist ^ shp) & mask) == '0) begin
                prefix = LEN_W'(k);
            end
        end
    end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with overlap control,
// prefix-progress output and a saturating match counter.
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(DEF_RST_PATTERN),
    parameter int RST_LEN = DEF_RST_LEN,
    parameter bit RST_OVERLAP = DEF_RST_OVERLAP,
    localparam int LEN_W = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in,
    input  logic               cnt_clr,
    output logic               out,
    output logic [LEN_W-1:0]   state,
    output logic [CNT_W-1:0]   match_cnt
);

    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    ovl_mode_e          overlap;

    logic [MAX_LEN-1:0] hist;
    logic [LEN_W-1:0]   fill;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   fill_nxt;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   len_in;
    logic [LEN_W-1:0]   prefix;
    logic               accept;
    logic               is_match;

    // Candidate history/fill for the incoming bit and the match decision.
    always_comb begin
        accept = in_valid && !cfg_load;
        hist_nxt = {hist[MAX_LEN-2:0], in};
        fill_inc = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
        len_mask = MAX_LEN'((64'd1 << len) - 64'd1);
        is_match = (len >= LEN_W'(2)) && (fill_inc >= len) &&
                   (((hist_nxt ^ pattern) & len_mask) == '0);
        fill_nxt = (is_match && overlap == OVL_RESTART) ? '0 : fill_inc;
        len_in = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
    end

    seq_prefix_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_prefix (
        .hist    (hist_nxt),
        .fill    (fill_nxt),
        .pattern (pattern),
        .len     (len),
        .prefix  (prefix)
    );

    // Config, history, fill and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= RST_PATTERN;
            len <= LEN_W'(RST_LEN);
            overlap <= ovl_mode_e'(RST_OVERLAP);
            hist <= '0;
            fill <= '0;
            state <= '0;
            out <= 1'b0;
        end else if (cfg_load) begin
            pattern <= cfg_pattern;
            len <= len_in;
            overlap <= ovl_mode_e'(cfg_overlap);
            hist <= '0;
            fill <= '0;
            state <= '0;
            out <= 1'b0;
        end else if (in_valid) begin
            hist <= hist_nxt;
            fill <= fill_nxt;
            state <= prefix;
            out <= is_match;
        end else begin
            out <= 1'b0;
        end
    end

    // Saturating match counter; clear beats a simultaneous match.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            match_cnt <= '0;
        end else if (accept && is_match && match_cnt != '1) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_det_prog.sv
// Directed self-checking bench for seq_det_prog.
// Two instances: default widths, and a 2-bit counter variant.
module tb_seq_det_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cnt_clr = 1'b0;

    logic       out_a;
    logic [3:0] state_a;
    logic [7:0] cnt_a;
    logic       out_b;
    logic [3:0] state_b;
    logic [1:0] cnt_b;

    int n_chk = 0;
    int n_pass = 0;

    seq_det_prog dut_a (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in          (in_bit),
        .cnt_clr     (cnt_clr),
        .out         (out_a),
        .state       (state_a),
        .match_cnt   (cnt_a)
    );

    seq_det_prog #(.CNT_W(2)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in          (in_bit),
        .cnt_clr     (cnt_clr),
        .out         (out_b),
        .state       (state_b),
        .match_cnt   (cnt_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input logic b);
        in_valid = 1'b0;
        in_bit = b;
        tick();
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [3:0] l,
                            input logic ov, input logic clr);
        cfg_load = 1'b1;
        cfg_pattern = p;
        cfg_len = l;
        cfg_overlap = ov;
        cnt_clr = clr;
        in_valid = 1'b1;
        in_bit = 1'b1;
        tick();
        cfg_load = 1'b0;
        cnt_clr = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic b11 [11] = '{1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 1};
    logic o11 [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int   s11 [11] = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1};

    logic b7  [7] = '{1, 0, 1, 1, 0, 1, 1};
    logic o7n [7] = '{0, 0, 0, 1, 0, 0, 0};
    int   s7n [7] = '{1, 2, 3, 0, 0, 1, 1};
    logic o7o [7] = '{0, 0, 0, 1, 0, 0, 1};
    int   s7o [7] = '{1, 2, 3, 1, 2, 3, 1};

    logic b8  [8] = '{1, 1, 0, 0, 1, 0, 1, 0};

    initial begin
        int pulses;
        int bad_out;
        int bad_st;

        tick();
        tick();
        check("rst_out", 32'(out_a), 32'd0);
        check("rst_state", 32'(state_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;

        // Default pattern 101011, overlap on
        for (int i = 0; i < 11; i++) begin
            send(b11[i]);
            check($sformatf("def_out%0d", i), 32'(out_a), 32'(o11[i]));
            check($sformatf("def_st%0d", i), 32'(state_a), 32'(s11[i]));
        end
        check("def_cnt", 32'(cnt_a), 32'd2);
        idle(1'b1);
        check("def_idle_out", 32'(out_a), 32'd0);

        // Pattern 1011 without overlap
        load_cfg(8'b0000_1011, 4'd4, 1'b0, 1'b0);
        check("ld_state", 32'(state_a), 32'd0);
        check("ld_out", 32'(out_a), 32'd0);
        check("ld_cnt_kept", 32'(cnt_a), 32'd2);
        for (int i = 0; i < 7; i++) begin
            send(b7[i]);
            check($sformatf("nov_out%0d", i), 32'(out_a), 32'(o7n[i]));
            check($sformatf("nov_st%0d", i), 32'(state_a), 32'(s7n[i]));
        end

        // Same stimulus with overlap
        load_cfg(8'b0000_1011, 4'd4, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            send(b7[i]);
            check($sformatf("ov_out%0d", i), 32'(out_a), 32'(o7o[i]));
            check($sformatf("ov_st%0d", i), 32'(state_a), 32'(s7o[i]));
        end
        check("ov_cnt", 32'(cnt_a), 32'd5);

        // Default pattern with an idle cycle after every bit
        load_cfg(8'b0010_1011, 4'd6, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            send(b11[i]);
            check($sformatf("gap_out%0d", i), 32'(out_a), 32'(o11[i]));
            check($sformatf("gap_st%0d", i), 32'(state_a), 32'(s11[i]));
            idle(~b11[i]);
            check($sformatf("gap_idle_out%0d", i), 32'(out_a), 32'd0);
            check($sformatf("gap_idle_st%0d", i), 32'(state_a),
                  32'(s11[i]));
        end
        check("gap_cnt", 32'(cnt_a), 32'd6);

        // Reset mid-sequence
        for (int i = 0; i < 5; i++) send(b11[i]);
        check("pre_rst_st", 32'(state_a), 32'd5);
        do_reset();
        check("mid_rst_st", 32'(state_a), 32'd0);
        check("mid_rst_cnt", 32'(cnt_a), 32'd0);
        send(1'b1);
        check("post_rst_out", 32'(out_a), 32'd0);
        check("post_rst_st", 32'(state_a), 32'd1);

        // Length 0 disables detection
        load_cfg(8'b0000_0000, 4'd0, 1'b1, 1'b0);
        bad_out = 0;
        bad_st = 0;
        for (int i = 0; i < 64; i++) begin
            send(1'($urandom_range(0, 1)));
            if (out_a !== 1'b0) bad_out++;
            if (state_a !== 4'd0) bad_st++;
        end
        check("len0_out", 32'(bad_out), 32'd0);
        check("len0_state", 32'(bad_st), 32'd0);
        check("len0_cnt", 32'(cnt_a), 32'd0);

        // Length 1 also disables detection
        load_cfg(8'b0000_0001, 4'd1, 1'b1, 1'b0);
        send(1'b1);
        send(1'b1);
        check("len1_out", 32'(out_a), 32'd0);
        check("len1_state", 32'(state_a), 32'd0);

        // Length 12 clamps to 8
        load_cfg(8'b1100_1010, 4'd12, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send(b8[i]);
            check($sformatf("clamp_out%0d", i), 32'(out_a),
                  (i == 7) ? 32'd1 : 32'd0);
            if (i == 6) check("clamp_st6", 32'(state_a), 32'd7);
        end
        check("clamp_cnt", 32'(cnt_a), 32'd1);

        // 2-bit counter saturation, pattern 11, config load + clear together
        load_cfg(8'b0000_0011, 4'd2, 1'b1, 1'b1);
        check("sat_clr_ld", 32'(cnt_b), 32'd0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1);
            if (out_b === 1'b1) pulses++;
        end
        check("sat_pulses", 32'(pulses), 32'd7);
        check("sat_cnt", 32'(cnt_b), 32'd3);
        cnt_clr = 1'b1;
        send(1'b1);
        cnt_clr = 1'b0;
        check("clr_match_out", 32'(out_b), 32'd1);
        check("clr_match_cnt", 32'(cnt_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
